// File: rtl/regfile_pkg.sv
// Shared constants and write-port match helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
    localparam int unsigned MAX_WRITE          = 2;
    localparam int unsigned WIDX_W             = 1;

    typedef struct packed {
        logic              hit;
        logic [WIDX_W-1:0] idx;
    } wr_match_t;

    // Highest-index asserted hit wins, matching the write-port priority.
    function automatic wr_match_t highest_match(input logic [MAX_WRITE-1:0] hits);
        wr_match_t m;
        m = '0;
        for (int i = 0; i < MAX_WRITE; i++) begin
            if (hits[i]) begin
                m.hit = 1'b1;
                m.idx = WIDX_W'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: writes clear, reservations set, reservation wins on a tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_WRITE  = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [NUM_WRITE-1:0]                  write_enable,
    input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0]  write_address,
    input  logic                                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0]                 reserve_address,
    output logic [(2**ADDR_WIDTH)-1:0]            busy
);

    logic reserve_ok;

    assign reserve_ok = reserve_enable && !((ZERO_REG != 0) && (reserve_address == '0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_WRITE); i++) begin
                if (write_enable[i]) begin
                    busy[write_address[i]] <= 1'b0;
                end
            end
            if (reserve_ok) begin
                busy[reserve_address] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, optional zero register and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [NUM_WRITE-1:0]                  write_enable,
    input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0]  write_address,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]  write_data,
    input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]   read_address,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]   read_data,
    output logic [NUM_READ-1:0]                   read_busy,
    input  logic                                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0]                 reserve_address,
    output logic [(2**ADDR_WIDTH)-1:0]            busy_vector
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [DEPTH-1:0]                 busy;

    // Later loop iterations overwrite earlier ones, so the higher port wins a collision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_WRITE); i++) begin
                if (write_enable[i] && !((ZERO_REG != 0) && (write_address[i] == '0))) begin
                    mem[write_address[i]] <= write_data[i];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WRITE  (NUM_WRITE),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clock           (clock),
        .reset_n         (reset_n),
        .write_enable    (write_enable),
        .write_address   (write_address),
        .reserve_enable  (reserve_enable),
        .reserve_address (reserve_address),
        .busy            (busy)
    );

    assign busy_vector = busy;

    for (genvar j = 0; j < NUM_READ; j++) begin : g_read
        logic [MAX_WRITE-1:0]  hits;
        wr_match_t             match;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        always_comb begin
            hits = '0;
            for (int i = 0; i < int'(NUM_WRITE); i++) begin
                hits[i] = write_enable[i] && (write_address[i] == read_address[j]);
            end
            match = highest_match(hits);
        end

        // Reset and the zero register override both the array and the bypass path.
        always_comb begin
            rd = mem[read_address[j]];
            rb = busy[read_address[j]];
            if ((BYPASS != 0) && match.hit) begin
                for (int i = 0; i < int'(NUM_WRITE); i++) begin
                    if (match.idx == WIDX_W'(i)) begin
                        rd = write_data[i];
                    end
                end
                if (!(reserve_enable && (reserve_address == read_address[j]))) begin
                    rb = 1'b0;
                end
            end
            if (!reset_n || ((ZERO_REG != 0) && (read_address[j] == '0))) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign read_data[j] = rd;
        assign read_busy[j] = rb;
    end

endmodule
